uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Serial program loader feeding the Hazard2 SoC instruction memory. While `load_en` is high, it receives an 8N1 UART byte stream and packs it into 32-bit little-endian words. Each word is written through a single-cycle write port, and the CPU is held via `cpu_hold` until the programmed word count has been stored. The block sits between the external `read_uart` request and the SoC's instruction RAM and reset gating.

## Interface
- `CLK_DIV`, 868, HCLK cycles per UART bit (100 MHz / 115200); minimum 4
- `ADDR_W`, 12, word-address width of instruction RAM
- One clock; reset is synchronous and active-high.
- `HCLK` in 1: system clock; all state on rising edge
- `HRESET` in 1: synchronous active-high reset
- `load_en` in 1: load request (driven from `read_uart`); rising edge starts a session
- `rx` in 1: UART receive line, idle high, asynchronous to HCLK
- `mem_we` out 1: one-cycle write strobe
- `mem_addr` out ADDR_W: word address of current write
- `mem_wdata` out 32: word data, valid when `mem_we`=1
- `cpu_hold` out 1: high while a session is active; SoC keeps CPU in reset
- `done` out 1: sticky, set when all words written; cleared at next session start
- `frame_err` out 1: sticky, set on bad stop bit; cleared at next session start
- `words_written` out 16: count of words written this session

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) before use.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START on synchronized `rx`=0.
  - R_START waits CLK_DIV/2 cycles, then re-samples. If `rx`=1, it returns to R_IDLE (glitch). If `rx`=0, it goes to R_DATA.
  - R_DATA samples 8 bits LSB-first, one every CLK_DIV cycles.
  - R_STOP samples once after CLK_DIV cycles. If 1, it emits a one-cycle internal `byte_valid`. If 0, it sets `frame_err` and drops the byte. In both cases it returns to R_IDLE.
  - The RX FSM runs regardless of `load_en`. Bytes outside a session are ignored.
- Loader FSM states: L_IDLE, L_HDR0, L_HDR1, L_DATA, L_DONE.
  - L_IDLE → L_HDR0 on `load_en` rising edge. This clears `done`, `frame_err`, `words_written`, the address, and the byte lane, and sets `cpu_hold`=1.
  - L_HDR0 captures byte as count[7:0]. L_HDR1 captures count[15:8].
  - If count=0, L_HDR1 goes to L_DONE. Otherwise it goes to L_DATA.
  - L_DATA places bytes into lanes 0..3; byte k goes to `mem_wdata[8k+7:8k]`. After lane 3, it issues `mem_we` and increments the address and `words_written`. When `words_written` reaches count, it goes to L_DONE.
  - L_DONE sets `done`=1 and `cpu_hold`=0, then returns to L_IDLE.
- `load_en` falling while in L_HDR0/L_HDR1/L_DATA aborts the session:
  - FSM goes to L_IDLE and `cpu_hold` drops the next cycle.
  - `done` stays 0 and any partial word is discarded.
  - Words already written remain in RAM.
- `load_en` high past L_DONE does not restart a session; a new rising edge is required.
- `mem_addr` wraps modulo 2^ADDR_W if count exceeds RAM depth. `words_written` does not wrap below 65535.
- A framing error does not abort the session. The dropped byte is simply not counted.
- `HRESET` mid-session returns all FSMs to idle and discards any partial byte or word.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `cpu_hold`=0, `done`=0, `frame_err`=0, `words_written`=0
  - synchronizer flops = 1
- Start-bit detect latency is 2 cycles from the `rx` falling edge (synchronizer).
- `byte_valid` asserts at the stop-bit mid-sample, about 9.5×CLK_DIV + 2 cycles after the start edge.
- `mem_we` asserts exactly 1 cycle after the `byte_valid` of lane 3. `mem_addr` and `mem_wdata` are stable in that same cycle.
- `done` rises and `cpu_hold` falls 1 cycle after the final `mem_we`, or 1 cycle after `byte_valid` of the header's high byte when count=0.
- `cpu_hold` rises the cycle after the `load_en` rising edge.
- `byte_valid` coinciding with `load_en` falling: the abort takes priority and the byte is ignored.

## Test plan
(all with `CLK_DIV`=8)
- Reset: hold `HRESET` 3 cycles → all outputs 0, synchronizer 1, no `mem_we` with `rx` toggling.
- Normal load: pulse `load_en` high, send 02 00 78 56 34 12 EF BE AD DE → `mem_we` at addr 0 with 0x12345678 and addr 1 with 0xDEADBEEF; `done`=1, `cpu_hold`=0, `words_written`=2.
- Zero count: send 00 00 → no `mem_we`; `done`=1 one cycle after the second byte.
- Framing error: header 01 00, then a data byte with stop bit 0, then 11 22 33 44 → `frame_err`=1, one write of 0x44332211 at addr 0, `done`=1.
- Abort: header 03 00 and 6 data bytes, then drop `load_en` → exactly one write, `cpu_hold`=0, `done`=0. The next `load_en` edge clears `words_written` to 0.
- Glitch and wrap: a 2-cycle low pulse on `rx` produces no byte. With `ADDR_W`=2 and count=5, the fifth write goes to `mem_addr`=0 and `words_written`=5.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Loader-side signal bundle: UART line and load request in, instruction-RAM write port and status out.
// The slave modport is the loader itself; the master modport is whoever drives rx/load_en and watches the RAM port.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic              load_en;
  logic              rx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              frame_err;
  logic [15:0]       words_written;

  modport slave (
    input  load_en, rx,
    output mem_we, mem_addr, mem_wdata, cpu_hold, done, frame_err, words_written
  );

  modport master (
    output load_en, rx,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, done, frame_err, words_written
  );
endinterface

// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver packing a length-prefixed byte stream into little-endian 32-bit RAM writes.
// mem_we fires 1 cycle after the fourth byte's stop sample; no backpressure, RAM must accept every strobe.
module uart_prog_loader #(
  parameter int CLK_DIV = 868,
  parameter int ADDR_W  = 12
) (
  input  logic              HCLK,
  input  logic              HRESET,
  uart_prog_loader_if.slave bus
);
  localparam int              CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_HDR0, L_HDR1, L_DATA, L_DONE} ld_state_t;

  logic            r_rx_meta, r_rx_sync;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_div_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_div_clr, w_shift_en, w_byte_vld, w_frame_bad;

  ld_state_t       r_ld_state, w_ld_next;
  logic            r_load_d;
  logic [15:0]     r_count;
  logic [1:0]      r_lane;
  logic [23:0]     r_word;
  logic            r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic            r_cpu_hold, r_done, r_frame_err;
  logic [15:0]     r_words;
  logic [15:0]     w_words_inc;
  logic            w_load_rise, w_load_fall;
  logic            w_start, w_abort, w_cap_lo, w_cap_hi, w_cap_lane, w_issue, w_finish;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_rx_state <= R_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next   = r_rx_state;
    w_div_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_vld  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_rx_state)
      R_IDLE: if (!r_rx_sync) begin
        w_rx_next = R_START;
        w_div_clr = 1'b1;
      end
      // Start bit is re-checked at its midpoint so short line glitches are rejected.
      R_START: if (r_div_cnt == HALF_M1) begin
        w_div_clr = 1'b1;
        w_rx_next = r_rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: if (r_div_cnt == FULL_M1) begin
        w_div_clr  = 1'b1;
        w_shift_en = 1'b1;
        if (r_bit_idx == 3'd7) w_rx_next = R_STOP;
      end
      R_STOP: if (r_div_cnt == FULL_M1) begin
        w_rx_next   = R_IDLE;
        w_byte_vld  = r_rx_sync;
        w_frame_bad = !r_rx_sync;
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_div_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_div_cnt <= w_div_clr ? '0 : r_div_cnt + CW'(1);
      if (w_shift_en) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign w_load_rise = bus.load_en & ~r_load_d;
  assign w_load_fall = ~bus.load_en & r_load_d;
  assign w_words_inc = r_words + 16'd1;

  always_ff @(posedge HCLK) begin
    if (HRESET) r_ld_state <= L_IDLE;
    else        r_ld_state <= w_ld_next;
  end

  // A falling load_en beats a coincident byte in every active state.
  always_comb begin
    w_ld_next  = r_ld_state;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    w_cap_lo   = 1'b0;
    w_cap_hi   = 1'b0;
    w_cap_lane = 1'b0;
    w_issue    = 1'b0;
    w_finish   = 1'b0;
    case (r_ld_state)
      L_IDLE: if (w_load_rise) begin
        w_start   = 1'b1;
        w_ld_next = L_HDR0;
      end
      L_HDR0: begin
        if (w_load_fall) begin
          w_abort   = 1'b1;
          w_ld_next = L_IDLE;
        end else if (w_byte_vld) begin
          w_cap_lo  = 1'b1;
          w_ld_next = L_HDR1;
        end
      end
      L_HDR1: begin
        if (w_load_fall) begin
          w_abort   = 1'b1;
          w_ld_next = L_IDLE;
        end else if (w_byte_vld) begin
          w_cap_hi = 1'b1;
          if ({r_shift, r_count[7:0]} == 16'd0) begin
            w_finish  = 1'b1;
            w_ld_next = L_DONE;
          end else begin
            w_ld_next = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (w_load_fall) begin
          w_abort   = 1'b1;
          w_ld_next = L_IDLE;
        end else begin
          if (w_byte_vld) begin
            w_cap_lane = 1'b1;
            w_issue    = (r_lane == 2'd3);
          end
          if (r_mem_we && (w_words_inc == r_count)) begin
            w_finish  = 1'b1;
            w_ld_next = L_DONE;
          end
        end
      end
      L_DONE:  w_ld_next = L_IDLE;
      default: w_ld_next = L_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_load_d    <= 1'b0;
      r_count     <= 16'd0;
      r_lane      <= 2'd0;
      r_word      <= 24'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_cpu_hold  <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_words     <= 16'd0;
    end else begin
      r_load_d <= bus.load_en;
      r_mem_we <= w_issue;
      if (w_cap_lo) r_count[7:0]  <= r_shift;
      if (w_cap_hi) r_count[15:8] <= r_shift;
      if (w_cap_lane) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_word[7:0]   <= r_shift;
          2'd1:    r_word[15:8]  <= r_shift;
          2'd2:    r_word[23:16] <= r_shift;
          default: r_mem_wdata   <= {r_shift, r_word};
        endcase
      end
      // Bookkeeping trails the strobe so mem_addr is still the written address while mem_we is high.
      if (r_mem_we) begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        if (r_words != 16'hFFFF) r_words <= w_words_inc;
      end
      if (w_start) begin
        r_done      <= 1'b0;
        r_frame_err <= 1'b0;
        r_words     <= 16'd0;
        r_mem_addr  <= '0;
        r_lane      <= 2'd0;
        r_cpu_hold  <= 1'b1;
      end
      if (w_frame_bad) r_frame_err <= 1'b1;
      if (w_abort)     r_cpu_hold  <= 1'b0;
      if (w_finish) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
    end
  end

  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.cpu_hold      = r_cpu_hold;
  assign bus.done          = r_done;
  assign bus.frame_err     = r_frame_err;
  assign bus.words_written = r_words;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at CLK_DIV=8, ADDR_W=2; bytes are bit-banged on rx, writes logged by a monitor.
module tb_uart_prog_loader;
  localparam int CLK_DIV = 8;
  localparam int ADDR_W  = 2;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0, wr_cnt = 0, last_we_cyc = 0, done_rise_cyc = 0, base = 0;
  logic done_q = 1'b0;
  logic [ADDR_W-1:0] wa [$];
  logic [31:0]       wd [$];

  always @(negedge HCLK) begin
    cyc++;
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      wr_cnt++;
      last_we_cyc = cyc;
    end
    if (bus.done === 1'b1 && !done_q) done_rise_cyc = cyc;
    done_q = (bus.done === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Start bit plus 8 data bits; caller drives the stop bit.
  task automatic tx_head(input logic [7:0] b);
    bus.rx = 1'b0;
    cycles(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      cycles(CLK_DIV);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    tx_head(b);
    bus.rx = stop_bit;
    cycles(CLK_DIV);
    bus.rx = 1'b1;
    cycles(2 * CLK_DIV);
  endtask

  task automatic new_session();
    bus.load_en = 1'b0;
    cycles(2);
    bus.load_en = 1'b1;
    cycles(1);
  endtask

  logic [7:0] normal_bytes [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    HRESET      = 1'b1;
    bus.load_en = 1'b0;
    bus.rx      = 1'b1;

    // Reset held 3 cycles while rx toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      bus.rx = ~bus.rx;
    end
    chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_hold",  32'(bus.cpu_hold), 32'd0);
    chk("rst_done",      32'(bus.done), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_words",     32'(bus.words_written), 32'd0);
    chk("rst_sync_meta", 32'(dut.r_rx_meta), 32'd1);
    chk("rst_sync_out",  32'(dut.r_rx_sync), 32'd1);
    HRESET = 1'b0;
    bus.rx = 1'b1;
    cycles(20);
    chk("rst_no_write", wr_cnt, 0);

    // Normal two-word load
    bus.load_en = 1'b1;
    chk("hold_before_edge", 32'(bus.cpu_hold), 32'd0);
    cycles(1);
    chk("hold_after_edge", 32'(bus.cpu_hold), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(normal_bytes[i], 1'b1);
    chk("norm_wr_cnt", wr_cnt, 2);
    chk("norm_addr0",  32'(wa[0]), 32'd0);
    chk("norm_data0",  wd[0], 32'h12345678);
    chk("norm_addr1",  32'(wa[1]), 32'd1);
    chk("norm_data1",  wd[1], 32'hDEADBEEF);
    chk("norm_done",   32'(bus.done), 32'd1);
    chk("norm_hold",   32'(bus.cpu_hold), 32'd0);
    chk("norm_words",  32'(bus.words_written), 32'd2);
    chk("norm_ferr",   32'(bus.frame_err), 32'd0);
    chk("norm_done_lat", done_rise_cyc - last_we_cyc, 1);

    // Zero count: done exactly one cycle after the high header byte
    base = wr_cnt;
    new_session();
    chk("zero_done_clr", 32'(bus.done), 32'd0);
    chk("zero_words_clr", 32'(bus.words_written), 32'd0);
    send_byte(8'h00, 1'b1);
    tx_head(8'h00);
    bus.rx = 1'b1;
    cycles(CLK_DIV - 2);
    chk("zero_done_early", 32'(bus.done), 32'd0);
    cycles(1);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_hold", 32'(bus.cpu_hold), 32'd0);
    cycles(CLK_DIV + 2 * CLK_DIV - 1);
    chk("zero_no_write", wr_cnt, base);

    // Framing error mid-stream
    base = wr_cnt;
    new_session();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("ferr_flag",   32'(bus.frame_err), 32'd1);
    chk("ferr_wr_cnt", wr_cnt, base + 1);
    chk("ferr_addr",   32'(wa[base]), 32'd0);
    chk("ferr_data",   wd[base], 32'h44332211);
    chk("ferr_done",   32'(bus.done), 32'd1);
    chk("ferr_words",  32'(bus.words_written), 32'd1);

    // Abort after one and a half words
    base = wr_cnt;
    new_session();
    chk("abort_ferr_clr", 32'(bus.frame_err), 32'd0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    chk("abort_hold_pre", 32'(bus.cpu_hold), 32'd1);
    bus.load_en = 1'b0;
    cycles(2);
    chk("abort_hold",    32'(bus.cpu_hold), 32'd0);
    chk("abort_done",    32'(bus.done), 32'd0);
    chk("abort_wr_cnt",  wr_cnt, base + 1);
    chk("abort_data",    wd[base], 32'h04030201);
    chk("abort_words",   32'(bus.words_written), 32'd1);
    bus.load_en = 1'b1;
    cycles(1);
    chk("restart_words", 32'(bus.words_written), 32'd0);
    chk("restart_hold",  32'(bus.cpu_hold), 32'd1);

    // Glitch then 5 words into a 4-entry RAM
    base = wr_cnt;
    bus.rx = 1'b0;
    cycles(2);
    bus.rx = 1'b1;
    cycles(4 * CLK_DIV);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 20; i++) send_byte(8'(i), 1'b1);
    chk("wrap_wr_cnt", wr_cnt, base + 5);
    chk("wrap_data0",  wd[base], 32'h04030201);
    chk("wrap_addr3",  32'(wa[base + 3]), 32'd3);
    chk("wrap_addr4",  32'(wa[base + 4]), 32'd0);
    chk("wrap_data4",  wd[base + 4], 32'h14131211);
    chk("wrap_words",  32'(bus.words_written), 32'd5);
    chk("wrap_done",   32'(bus.done), 32'd1);

    // Reset mid-session discards the partial word
    new_session();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    HRESET      = 1'b1;
    bus.load_en = 1'b0;
    cycles(1);
    chk("mrst_hold",  32'(bus.cpu_hold), 32'd0);
    chk("mrst_addr",  32'(bus.mem_addr), 32'd0);
    chk("mrst_done",  32'(bus.done), 32'd0);
    HRESET = 1'b0;
    base = wr_cnt;
    new_session();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hC4, 1'b1);
    chk("mrst_wr_cnt", wr_cnt, base + 1);
    chk("mrst_data",   wd[base], 32'hC4C3C2C1);
    chk("mrst_done2",  32'(bus.done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
